// File: rtl/arb_pkg.sv
// Shared types and constants for the burst arbiter: FSM state encoding and
// the width of the grantee index.
package arb_pkg;

  localparam int unsigned GidW = 3;

  typedef enum logic {
    StArb,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/burst_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the output FIFO.
// The arbiter uses the master view and the surrounding logic uses the slave view.
interface burst_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DW    = 32
);

  logic [N_REQ*DW-1:0] receive_data;
  logic [N_REQ-1:0]    receive_request;
  logic [N_REQ-1:0]    receive_valid;
  logic [DW-1:0]       send_data0;
  logic                send_request0;
  logic                send_valid0;
  logic [GidW-1:0]     grant_id;
  logic                grant_active;

  modport master (
    input  receive_data,
    input  receive_request,
    input  send_valid0,
    output receive_valid,
    output send_data0,
    output send_request0,
    output grant_id,
    output grant_active
  );

  modport slave (
    output receive_data,
    output receive_request,
    output send_valid0,
    input  receive_valid,
    input  send_data0,
    input  send_request0,
    input  grant_id,
    input  grant_active
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first requesting index strictly after last_i, wrapping to 0.
// Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GidW-1:0]  last_i,
  output logic [GidW-1:0]  next_o,
  output logic             found_o
);

  // The first pass covers indices above last_i and the second pass wraps to the rest.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found_o && req_i[i] && (i > int'(last_i))) begin
        found_o = 1'b1;
        next_o  = GidW'(i);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found_o && req_i[i]) begin
        found_o = 1'b1;
        next_o  = GidW'(i);
      end
    end
  end

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: it grants one requester for up to MAX_BURST words and
// moves those words through a single output register to a FIFO-style sink.
module burst_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  burst_arbiter_if.master arb_io
);

  localparam logic [7:0] LastBeat = 8'(MAX_BURST - 1);

  arb_state_e      state_q;
  logic [GidW-1:0] last_grant_q;
  logic [GidW-1:0] grant_id_q;
  logic [7:0]      burst_cnt_q;
  logic            grant_active_q;
  logic            send_request0_q;
  logic [DW-1:0]   send_data0_q;

  logic [GidW-1:0]  pick;
  logic             pick_found;
  logic             transfer;
  logic             slot_free;
  logic             grantee_req;
  logic [DW-1:0]    grantee_data;
  logic             accept;
  logic             burst_end;
  logic [N_REQ-1:0] receive_valid;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i  (arb_io.receive_request),
    .last_i (last_grant_q),
    .next_o (pick),
    .found_o(pick_found)
  );

  always_comb begin
    grantee_req  = 1'b0;
    grantee_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_id_q == GidW'(i)) begin
        grantee_req  = arb_io.receive_request[i];
        grantee_data = arb_io.receive_data[i*DW +: DW];
      end
    end
  end

  // The output register can take a word when it is empty or is draining this cycle.
  assign transfer  = send_request0_q && arb_io.send_valid0;
  assign slot_free = !send_request0_q || transfer;
  assign accept    = (state_q == StGrant) && grantee_req && slot_free;
  assign burst_end = (accept && (burst_cnt_q == LastBeat)) || !grantee_req;

  always_comb begin
    receive_valid = '1;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if ((state_q == StGrant) && (grant_id_q == GidW'(i)) && slot_free) begin
        receive_valid[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StArb;
      last_grant_q   <= GidW'(N_REQ - 1);
      grant_id_q     <= '0;
      burst_cnt_q    <= '0;
      grant_active_q <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (pick_found) begin
            state_q        <= StGrant;
            grant_active_q <= 1'b1;
            grant_id_q     <= pick;
            burst_cnt_q    <= '0;
          end
        end
        StGrant: begin
          if (accept) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
          if (burst_end) begin
            state_q        <= StArb;
            grant_active_q <= 1'b0;
            last_grant_q   <= grant_id_q;
          end
        end
      endcase
    end
  end

  // The output register drains independently of the grant state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send_request0_q <= 1'b0;
      send_data0_q    <= '0;
    end else if (accept) begin
      send_request0_q <= 1'b1;
      send_data0_q    <= grantee_data;
    end else if (transfer) begin
      send_request0_q <= 1'b0;
    end
  end

  assign arb_io.receive_valid = receive_valid;
  assign arb_io.send_data0    = send_data0_q;
  assign arb_io.send_request0 = send_request0_q;
  assign arb_io.grant_id      = grant_id_q;
  assign arb_io.grant_active  = grant_active_q;

endmodule

// File: tb/tb_burst_arbiter.sv
// Bench for burst_arbiter: two instances (MAX_BURST 16 and 4) share directed stimulus and
// are compared each cycle against a behavioural model, with extra literal expectations.
module tb_burst_arbiter;
  import arb_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  burst_arbiter_if #(.N_REQ(N), .DW(W)) bus0 ();
  burst_arbiter_if #(.N_REQ(N), .DW(W)) bus1 ();

  burst_arbiter #(.N_REQ(N), .DW(W), .MAX_BURST(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .arb_io(bus0)
  );

  burst_arbiter #(.N_REQ(N), .DW(W), .MAX_BURST(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .arb_io(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Stimulus state shared by both instances; each instance has its own source queues.
  bit             en [N];
  bit             svalid;
  bit             hold_chk;
  logic [W-1:0]   hold_word;
  int             seq [N];
  logic [W-1:0]   src_q [2*N][$];

  // Behavioural model per instance.
  bit           m_act  [2];
  int           m_gid  [2];
  int           m_last [2];
  int           m_cnt  [2];
  bit           m_oval [2];
  logic [W-1:0] m_oword[2];
  int           grant_log [2][$];
  logic [W-1:0] obs  [2][$];
  int           tcyc [2][$];

  function automatic int mb(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic [W-1:0] word(input int src, input int k);
    return {8'(src), 24'(k)};
  endfunction

  function automatic int span(input int d);
    if (tcyc[d].size() == 0) return -1;
    return tcyc[d][tcyc[d].size()-1] - tcyc[d][0];
  endfunction

  function automatic bit idle();
    for (int j = 0; j < 2*N; j++) if (src_q[j].size() != 0) return 1'b0;
    return !m_oval[0] && !m_oval[1];
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got 0x%0h want 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [N-1:0] req, input logic [N*W-1:0] dat,
                       input bit sv);
    if (d == 0) begin
      bus0.receive_request = req;
      bus0.receive_data    = dat;
      bus0.send_valid0     = sv;
    end else begin
      bus1.receive_request = req;
      bus1.receive_data    = dat;
      bus1.send_valid0     = sv;
    end
  endtask

  task automatic sample(input int d, output logic [N-1:0] rv, output logic sr,
                        output logic [W-1:0] sd, output logic ga, output logic [2:0] gi);
    if (d == 0) begin
      rv = bus0.receive_valid; sr = bus0.send_request0; sd = bus0.send_data0;
      ga = bus0.grant_active;  gi = bus0.grant_id;
    end else begin
      rv = bus1.receive_valid; sr = bus1.send_request0; sd = bus1.send_data0;
      ga = bus1.grant_active;  gi = bus1.grant_id;
    end
  endtask

  task automatic push_words(input int i, input int n);
    for (int k = 0; k < n; k++)
      for (int d = 0; d < 2; d++) src_q[d*N+i].push_back(word(i, seq[i] + k));
    seq[i] += n;
  endtask

  task automatic check_reset_vals(input string name);
    logic [N-1:0] rv, ones;
    logic sr, ga;
    logic [W-1:0] sd;
    logic [2:0] gi;
    ones = '1;
    for (int d = 0; d < 2; d++) begin
      sample(d, rv, sr, sd, ga, gi);
      check({name, " receive_valid"}, d, 64'(rv), 64'(ones));
      check({name, " send_request0"}, d, 64'(sr), 64'(0));
      check({name, " send_data0"}, d, 64'(sd), 64'(0));
      check({name, " grant_active"}, d, 64'(ga), 64'(0));
      check({name, " grant_id"}, d, 64'(gi), 64'(0));
    end
  endtask

  // Called just after a rising edge; reset is asserted between edges.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin en[i] = 1'b0; seq[i] = 0; end
    hold_chk = 1'b0;
    for (int d = 0; d < 2; d++) drive(d, '0, '0, svalid);
    #1 check_reset_vals("reset async");
    @(posedge clk);
    #1 check_reset_vals("reset held");
    #1 reset = 1'b0;
    for (int j = 0; j < 2*N; j++) src_q[j].delete();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_gid[d] = 0; m_last[d] = N - 1; m_cnt[d] = 0;
      m_oval[d] = 1'b0; m_oword[d] = '0;
      grant_log[d].delete(); obs[d].delete(); tcyc[d].delete();
    end
  endtask

  task automatic cycle();
    logic [N-1:0]   req_v [2];
    logic [N*W-1:0] dat_v [2];
    logic [N-1:0]   rv, exp_rv;
    logic           sr, ga;
    logic [W-1:0]   sd;
    logic [2:0]     gi;
    bit             sv, xfer, slot, acc, found, ended;
    int             g, c;
    sv = svalid;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0;
      dat_v[d] = '0;
      for (int i = 0; i < N; i++) begin
        if (en[i] && src_q[d*N+i].size() > 0) begin
          req_v[d][i] = 1'b1;
          dat_v[d][i*W +: W] = src_q[d*N+i][0];
        end
      end
      drive(d, req_v[d], dat_v[d], sv);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sample(d, rv, sr, sd, ga, gi);
      g    = m_gid[d];
      xfer = m_oval[d] && sv;
      slot = !m_oval[d] || xfer;
      acc  = m_act[d] && req_v[d][g] && slot;
      exp_rv = '1;
      if (m_act[d] && slot) exp_rv[g] = 1'b0;
      check("receive_valid", d, 64'(rv), 64'(exp_rv));
      check("send_request0", d, 64'(sr), 64'(m_oval[d]));
      if (m_oval[d]) check("send_data0", d, 64'(sd), 64'(m_oword[d]));
      check("grant_active", d, 64'(ga), 64'(m_act[d]));
      if (m_act[d]) check("grant_id", d, 64'(gi), 64'(g));
      if (hold_chk) begin
        check("stall data held", d, 64'(sd), 64'(hold_word));
        check("stall receive_valid0", d, 64'(rv[0]), 64'(1));
      end
      if (sr && sv) begin
        obs[d].push_back(sd);
        tcyc[d].push_back(cyc);
      end
      if (acc) begin
        m_oword[d] = src_q[d*N+g].pop_front();
        m_oval[d]  = 1'b1;
      end else if (xfer) begin
        m_oval[d] = 1'b0;
      end
      if (!m_act[d]) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last[d] + k) % N;
          if (!found && req_v[d][c]) begin
            found = 1'b1;
            m_act[d] = 1'b1; m_gid[d] = c; m_cnt[d] = 0;
            grant_log[d].push_back(c);
          end
        end
      end else begin
        ended = !req_v[d][g] || (acc && (m_cnt[d] + 1 == mb(d)));
        if (acc) m_cnt[d]++;
        if (ended) begin m_act[d] = 1'b0; m_last[d] = g; end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while (!idle() && c < maxc) begin cycle(); c++; end
    n_cmp++;
    if (!idle()) begin
      n_bad++;
      $display("FAIL %s drain: got busy after %0d cycles want idle", name, maxc);
    end
    repeat (3) cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish by 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rv;
    logic sr, ga;
    logic [W-1:0] sd;
    logic [2:0] gi;
    svalid = 1'b1;
    do_reset();

    // Lone requester streams 40 words.
    en[0] = 1'b1;
    push_words(0, 40);
    drain("single", 200);
    for (int d = 0; d < 2; d++) begin
      check("single count", d, 64'(obs[d].size()), 64'(40));
      for (int k = 0; k < 40; k++)
        if (k < obs[d].size()) check("single order", d, 64'(obs[d][k]), 64'(word(0, k)));
    end
    check("single span", 0, 64'(span(0)), 64'(41));
    check("single span", 1, 64'(span(1)), 64'(48));
    check("single grants", 0, 64'(grant_log[0].size()), 64'(3));
    check("single grants", 1, 64'(grant_log[1].size()), 64'(10));

    // Two saturated requesters.
    do_reset();
    push_words(0, 12);
    push_words(1, 12);
    en[0] = 1'b1; en[1] = 1'b1;
    drain("sat", 200);
    check("sat grants", 1, 64'(grant_log[1].size()), 64'(6));
    for (int k = 0; k < 6; k++)
      if (k < grant_log[1].size()) check("sat grant seq", 1, 64'(grant_log[1][k]), 64'(k % 2));
    check("sat grants", 0, 64'(grant_log[0].size()), 64'(2));
    for (int d = 0; d < 2; d++) check("sat count", d, 64'(obs[d].size()), 64'(24));
    for (int k = 0; k < 24; k++) begin
      if (k < obs[1].size())
        check("sat groups", 1, 64'(obs[1][k]), 64'(word((k / 4) % 2, (k / 8) * 4 + k % 4)));
      if (k < obs[0].size())
        check("sat groups", 0, 64'(obs[0][k]), 64'(word(k / 12, k % 12)));
    end

    // Backpressure for five cycles mid-burst.
    do_reset();
    push_words(0, 10);
    en[0] = 1'b1;
    hold_word = word(0, 2);
    for (int c = 0; c < 10; c++) begin
      svalid   = !(c >= 4 && c <= 8);
      hold_chk = (c >= 4 && c <= 8);
      cycle();
    end
    hold_chk = 1'b0;
    svalid   = 1'b1;
    drain("stall", 100);
    for (int d = 0; d < 2; d++) begin
      check("stall count", d, 64'(obs[d].size()), 64'(10));
      for (int k = 0; k < 10; k++)
        if (k < obs[d].size()) check("stall order", d, 64'(obs[d][k]), 64'(word(0, k)));
    end

    // Early release by requester 1 after two words.
    do_reset();
    push_words(1, 6);
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (3) cycle();
    en[1] = 1'b0;
    push_words(0, 4);
    cycle();
    for (int d = 0; d < 2; d++) begin
      sample(d, rv, sr, sd, ga, gi);
      check("release gap", d, 64'(ga), 64'(0));
    end
    cycle();
    for (int d = 0; d < 2; d++) begin
      sample(d, rv, sr, sd, ga, gi);
      check("release regrant active", d, 64'(ga), 64'(1));
      check("release regrant id", d, 64'(gi), 64'(0));
    end
    en[1] = 1'b1;
    drain("release", 100);
    for (int d = 0; d < 2; d++) begin
      if (grant_log[d].size() >= 2) begin
        check("release first grant", d, 64'(grant_log[d][0]), 64'(1));
        check("release second grant", d, 64'(grant_log[d][1]), 64'(0));
      end else check("release grant count", d, 64'(grant_log[d].size()), 64'(2));
      if (obs[d].size() >= 3) begin
        check("release word0", d, 64'(obs[d][0]), 64'(word(1, 0)));
        check("release word1", d, 64'(obs[d][1]), 64'(word(1, 1)));
        check("release word2", d, 64'(obs[d][2]), 64'(word(0, 0)));
      end else check("release count", d, 64'(obs[d].size()), 64'(10));
    end

    // Reset mid-burst with a word in flight, then both requesters.
    do_reset();
    push_words(1, 20);
    en[1] = 1'b1;
    repeat (3) cycle();
    do_reset();
    push_words(0, 3);
    push_words(1, 3);
    en[0] = 1'b1; en[1] = 1'b1;
    drain("post-reset", 100);
    for (int d = 0; d < 2; d++) begin
      if (grant_log[d].size() > 0)
        check("post-reset first grant", d, 64'(grant_log[d][0]), 64'(0));
      else check("post-reset grant count", d, 64'(0), 64'(1));
      if (obs[d].size() > 0) check("post-reset first word", d, 64'(obs[d][0]), 64'(word(0, 0)));
      check("post-reset count", d, 64'(obs[d].size()), 64'(6));
    end

    // Sustained one word per cycle through a full burst.
    do_reset();
    push_words(0, 16);
    en[0] = 1'b1;
    drain("stream", 100);
    check("stream count", 0, 64'(obs[0].size()), 64'(16));
    check("stream span", 0, 64'(span(0)), 64'(15));
    check("stream span", 1, 64'(span(1)), 64'(18));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
